mem_responder: RTL and testbench

- Memory-side responder for the CPU's MAR/MDR memory interface. It services the Read and Write strobes that the control unit raises in fetch, ld and st cycles.
- It latches the address and write data, inserts a configurable number of wait states, and then performs one access into a word-addressed RAM array. Completion is signalled with a one-cycle Ready pulse.
- It sits between the MAR/MDR registers and the memory array. It replaces the zero-latency RAM so the datapath can be exercised against slow memory.

---
 rtl/mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the CPU's MAR/MDR interface. A single Read or
// Write strobe is latched together with the address and write data. After
// WAIT_CYCLES wait states, one access is made into a word-addressed RAM.
// Completion is reported with a one-cycle Ready pulse.
//
// The responder stands in for a zero-latency RAM, so the datapath can be
// exercised against slow memory. A strobe that is held high produces exactly
// one access: the FSM parks in RELEASE until both strobes fall.
//
// Ports:
//   clock     in   1       system clock, all state changes on posedge
//   clear     in   1       synchronous active-high reset (RAM contents kept)
//   Read      in   1       read request strobe (level)
//   Write     in   1       write request strobe (level)
//   address   in   ADDR_W  word address from MAR
//   data_in   in   DATA_W  write data from MDR
//   data_out  out  DATA_W  read data, held until the next completed read
//   Ready     out  1       one-cycle completion pulse
//   busy      out  1       high while a request is in progress
//   error     out  1       one-cycle pulse with Ready on a rejected request
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              Ready,
  output logic              busy,
  output logic              error
);

  // The RAM index only needs enough bits to cover the implemented words.
  // The full latched address is still used for the range check.
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_count;
  logic [3:0]        w_count_next;

  // Request captured in IDLE; later changes on the inputs are ignored.
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_op_write;

  logic              r_ready;
  logic              r_busy;
  logic              r_error;
  logic [DATA_W-1:0] r_data_out;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              w_latch;
  logic              w_ready_next;
  logic              w_busy_next;
  logic              w_error_next;
  logic              w_mem_we;
  logic              w_dout_load;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_latch      = 1'b0;
    w_ready_next = 1'b0;
    w_error_next = 1'b0;
    w_busy_next  = r_busy;
    w_mem_we     = 1'b0;
    w_dout_load  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Read && Write) begin
          // Ambiguous request: reject it at once, with no RAM access.
          w_state_next = S_DONE;
          w_ready_next = 1'b1;
          w_error_next = 1'b1;
          w_busy_next  = 1'b0;
        end else if (Read ^ Write) begin
          w_latch      = 1'b1;
          w_count_next = WAIT_L;
          w_busy_next  = 1'b1;
          w_state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end

      S_WAIT: begin
        w_count_next = r_count - 4'd1;
        if (r_count <= 4'd1) begin
          w_state_next = S_ACCESS;
        end
      end

      S_ACCESS: begin
        w_state_next = S_DONE;
        w_busy_next  = 1'b0;
        w_ready_next = 1'b1;
        w_error_next = !w_in_range;
        w_mem_we     = r_op_write && w_in_range;
        w_dout_load  = !r_op_write;
      end

      S_DONE: begin
        w_state_next = (Read || Write) ? S_RELEASE : S_IDLE;
      end

      S_RELEASE: begin
        if (!Read && !Write) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, request latch and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op_write <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_error <= w_error_next;
      if (w_latch) begin
        r_addr     <= address;
        r_wdata    <= data_in;
        r_op_write <= Write;
      end
      // An out-of-range read returns zero rather than an aliased word.
      if (w_dout_load) begin
        r_data_out <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  // RAM write port. Contents survive clear, but a write whose access edge
  // coincides with clear is abandoned.
  always_ff @(posedge clock) begin
    if (w_mem_we && !clear) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign data_out = r_data_out;
  assign Ready    = r_ready;
  assign busy     = r_busy;
  assign error    = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. It uses two instances:
//   dut_a : WAIT_CYCLES = 2, DEPTH = 256 (wait states, range checks, clear)
//   dut_b : WAIT_CYCLES = 0, DEPTH = 512 (zero-wait and back-to-back traffic)
//
// Latency is counted as the number of clock edges after the edge that
// samples the request, up to and including the edge that raises Ready.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        a_clear, a_read, a_write;
  logic [8:0]  a_addr;
  logic [31:0] a_din, a_dout;
  logic        a_ready, a_busy, a_error;

  logic        b_clear, b_read, b_write;
  logic [8:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic        b_ready, b_busy, b_error;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clock(clk), .clear(a_clear), .Read(a_read), .Write(a_write),
    .address(a_addr), .data_in(a_din), .data_out(a_dout),
    .Ready(a_ready), .busy(a_busy), .error(a_error)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) dut_b (
    .clock(clk), .clear(b_clear), .Read(b_read), .Write(b_write),
    .address(b_addr), .data_in(b_din), .data_out(b_dout),
    .Ready(b_ready), .busy(b_busy), .error(b_error)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle request, then wait (bounded) for Ready.
  // lat = -1 means that Ready never arrived.
  task automatic a_req(input logic rd, input logic wr, input logic [8:0] ad,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] dout, output logic err);
    lat = -1; dout = '0; err = 1'b0;
    a_read = rd; a_write = wr; a_addr = ad; a_din = d;
    cyc();
    a_read = 1'b0; a_write = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (a_ready) begin
        lat = k; dout = a_dout; err = a_error;
        break;
      end
      cyc();
    end
    cyc();
    $display("A rd=%0b wr=%0b addr=%h din=%h edges=%0d dout=%h err=%0b",
             rd, wr, ad, d, lat, dout, err);
  endtask

  task automatic b_req(input logic rd, input logic wr, input logic [8:0] ad,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] dout, output logic err);
    lat = -1; dout = '0; err = 1'b0;
    b_read = rd; b_write = wr; b_addr = ad; b_din = d;
    cyc();
    b_read = 1'b0; b_write = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (b_ready) begin
        lat = k; dout = b_dout; err = b_error;
        break;
      end
      cyc();
    end
    cyc();
    $display("B rd=%0b wr=%0b addr=%h din=%h edges=%0d dout=%h err=%0b",
             rd, wr, ad, d, lat, dout, err);
  endtask

  task automatic test_reset();
    a_clear = 1'b1; a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_din = '0;
    b_clear = 1'b1; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_din = '0;
    cyc(); cyc();
    a_clear = 1'b0; b_clear = 1'b0;
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_error !== 1'b0) begin n_errors++; $display("FAIL reset_error got=%b exp=0", a_error); end
    n_checks++; if (a_dout !== 32'h0) begin n_errors++; $display("FAIL reset_dout got=%h exp=0", a_dout); end
    n_checks++; if (b_dout !== 32'h0) begin n_errors++; $display("FAIL reset_b_dout got=%h exp=0", b_dout); end
    n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL reset_b_busy got=%b exp=0", b_busy); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e;
    a_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, lat, d, e);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL wr_error got=%b exp=0", e); end
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL wr_keeps_dout got=%h exp=0", d); end
    a_req(1'b1, 1'b0, 9'h010, 32'h0, lat, d, e);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL rd_error got=%b exp=0", e); end
  endtask

  task automatic test_held_read();
    int lat; logic [31:0] d; logic e; int pulses;
    a_req(1'b0, 1'b1, 9'h020, 32'h00000005, lat, d, e);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL preload_latency got=%0d exp=3", lat); end
    a_read = 1'b1; a_addr = 9'h020; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (a_ready) pulses++;
    end
    $display("A held read addr=020 for 10 cycles pulses=%0d dout=%h", pulses, a_dout);
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL held_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_dout !== 32'h5) begin n_errors++; $display("FAIL held_data got=%h exp=5", a_dout); end
    a_read = 1'b0;
    cyc(); cyc();
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL held_no_second got=%b exp=0", a_ready); end
    a_req(1'b1, 1'b0, 9'h010, 32'h0, lat, d, e);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL after_release_latency got=%0d exp=3", lat); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL after_release_data got=%h exp=deadbeef", d); end
  endtask

  task automatic test_both_strobes();
    int lat; logic [31:0] d; logic e;
    a_req(1'b0, 1'b1, 9'h030, 32'h30303030, lat, d, e);
    a_req(1'b1, 1'b1, 9'h030, 32'hFFFFFFFF, lat, d, e);
    n_checks++; if (lat != 0) begin n_errors++; $display("FAIL both_latency got=%0d exp=0", lat); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL both_error got=%b exp=1", e); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL both_dout_kept got=%h exp=deadbeef", d); end
    n_checks++; if (a_error !== 1'b0) begin n_errors++; $display("FAIL both_error_one_cycle got=%b exp=0", a_error); end
    a_req(1'b1, 1'b0, 9'h030, 32'h0, lat, d, e);
    n_checks++; if (d !== 32'h30303030) begin n_errors++; $display("FAIL both_array_kept got=%h exp=30303030", d); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL both_followup_error got=%b exp=0", e); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] d; logic e;
    a_req(1'b0, 1'b1, 9'h0FF, 32'hCAFEF00D, lat, d, e);
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL oor_edge_wr_error got=%b exp=0", e); end
    a_req(1'b0, 1'b1, 9'h1FF, 32'h12345678, lat, d, e);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL oor_wr_latency got=%0d exp=3", lat); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL oor_wr_error got=%b exp=1", e); end
    a_req(1'b1, 1'b0, 9'h0FF, 32'h0, lat, d, e);
    n_checks++; if (d !== 32'hCAFEF00D) begin n_errors++; $display("FAIL oor_no_alias got=%h exp=cafef00d", d); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL oor_inrange_error got=%b exp=0", e); end
    a_req(1'b1, 1'b0, 9'h1FF, 32'h0, lat, d, e);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL oor_rd_data got=%h exp=0", d); end
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL oor_rd_error got=%b exp=1", e); end
  endtask

  task automatic test_clear_mid();
    int lat; logic [31:0] d; logic e; int pulses;
    a_req(1'b0, 1'b1, 9'h040, 32'h11112222, lat, d, e);
    a_req(1'b1, 1'b0, 9'h0FF, 32'h0, lat, d, e);
    n_checks++; if (d !== 32'hCAFEF00D) begin n_errors++; $display("FAIL clr_setup_data got=%h exp=cafef00d", d); end
    // Clear while the write sits in WAIT.
    a_write = 1'b1; a_addr = 9'h040; a_din = 32'hAAAA5555;
    cyc();
    a_write = 1'b0;
    n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL clr_busy_before got=%b exp=1", a_busy); end
    cyc();
    a_clear = 1'b1;
    cyc();
    a_clear = 1'b0;
    $display("A clear during WAIT busy=%b ready=%b dout=%h", a_busy, a_ready, a_dout);
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL clr_busy got=%b exp=0", a_busy); end
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL clr_ready got=%b exp=0", a_ready); end
    n_checks++; if (a_error !== 1'b0) begin n_errors++; $display("FAIL clr_error got=%b exp=0", a_error); end
    n_checks++; if (a_dout !== 32'h0) begin n_errors++; $display("FAIL clr_dout got=%h exp=0", a_dout); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (a_ready) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL clr_abandoned got=%0d exp=0", pulses); end
    // Clear exactly on the ACCESS edge of a write.
    a_write = 1'b1; a_addr = 9'h040; a_din = 32'hBBBBCCCC;
    cyc();
    a_write = 1'b0;
    cyc(); cyc();
    a_clear = 1'b1;
    cyc();
    a_clear = 1'b0;
    $display("A clear on ACCESS edge ready=%b busy=%b", a_ready, a_busy);
    n_checks++; if (a_ready !== 1'b0) begin n_errors++; $display("FAIL clr_access_ready got=%b exp=0", a_ready); end
    a_req(1'b1, 1'b0, 9'h040, 32'h0, lat, d, e);
    n_checks++; if (d !== 32'h11112222) begin n_errors++; $display("FAIL clr_array_kept got=%h exp=11112222", d); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] d; logic e;
    b_req(1'b0, 1'b1, 9'h010, 32'h0BADF00D, lat, d, e);
    n_checks++; if (lat != 1) begin n_errors++; $display("FAIL zw_wr_latency got=%0d exp=1", lat); end
    b_req(1'b1, 1'b0, 9'h010, 32'h0, lat, d, e);
    n_checks++; if (lat != 1) begin n_errors++; $display("FAIL zw_rd_latency got=%0d exp=1", lat); end
    n_checks++; if (d !== 32'h0BADF00D) begin n_errors++; $display("FAIL zw_rd_data got=%h exp=0badf00d", d); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL zw_rd_error got=%b exp=0", e); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e;
    logic        t_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0]  t_addr [4] = '{9'h100, 9'h102, 9'h102, 9'h101};
    logic [31:0] t_din  [4] = '{32'h0, 32'h00000777, 32'h0, 32'h0};
    logic [31:0] t_exp  [4] = '{32'h0000100A, 32'h0000100A, 32'h00000777, 32'h0000101B};
    b_req(1'b0, 1'b1, 9'h100, 32'h0000100A, lat, d, e);
    b_req(1'b0, 1'b1, 9'h101, 32'h0000101B, lat, d, e);
    for (int i = 0; i < 4; i++) begin
      b_read = !t_wr[i]; b_write = t_wr[i]; b_addr = t_addr[i]; b_din = t_din[i];
      cyc();
      b_read = 1'b0; b_write = 1'b0;
      n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_early_ready[%0d] got=%b exp=0", i, b_ready); end
      cyc();
      $display("B b2b[%0d] wr=%0b addr=%h ready=%b dout=%h", i, t_wr[i], t_addr[i], b_ready, b_dout);
      n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, b_ready); end
      n_checks++; if (b_dout !== t_exp[i]) begin n_errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, b_dout, t_exp[i]); end
      cyc();
      n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_single_pulse[%0d] got=%b exp=0", i, b_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_read();
    test_both_strobes();
    test_out_of_range();
    test_clear_mid();
    test_zero_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached without completion");
    $fatal(1);
  end

endmodule
